// File: rtl/infoframe_scheduler_pkg.sv
// Shared packet types, constants and the PB byte accessor used by the
// InfoFrame scheduler, its checksum unit and its interface.
package infoframe_scheduler_pkg;

    typedef logic [23:0] packet_header_t;
    typedef logic [55:0] packet_sub_t;
    typedef packet_sub_t [3:0] packet_subs_t;

    localparam packet_header_t NULL_HEADER = 24'h0;
    localparam int PB_MAX = 27;

    typedef enum logic {
        IDLE,
        SEND
    } sched_state_t;

    // PB_k lives in subpacket k/7, byte lane k%7.
    function automatic logic [7:0] pb_byte(input packet_subs_t sub, input int k);
        logic [1:0] word;
        logic [5:0] lsb;
        word = 2'(k / 7);
        lsb  = 6'(8 * (k % 7));
        return sub[word][lsb +: 8];
    endfunction

endpackage

// File: rtl/infoframe_scheduler_if.sv
// Bundle between the InfoFrame generators, the scheduler and the packet assembler.
interface infoframe_scheduler_if
    import infoframe_scheduler_pkg::*;
#(
    parameter int NUM_SOURCES = 4
);

    localparam int GW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic                   video_field_end;
    logic                   packet_enable;
    logic [NUM_SOURCES-1:0] src_enable;
    packet_header_t         src_header [NUM_SOURCES];
    packet_subs_t           src_sub    [NUM_SOURCES];

    packet_header_t         header;
    packet_subs_t           sub;
    logic                   packet_valid;
    logic [GW-1:0]          grant_id;
    logic                   overrun;
    logic [7:0]             frames_missed;

    modport master (
        output video_field_end, packet_enable, src_enable, src_header, src_sub,
        input  header, sub, packet_valid, grant_id, overrun, frames_missed
    );

    modport slave (
        input  video_field_end, packet_enable, src_enable, src_header, src_sub,
        output header, sub, packet_valid, grant_id, overrun, frames_missed
    );

endinterface

// File: rtl/infoframe_scheduler_checksum.sv
// Combinational InfoFrame checksum: two's complement of the header bytes plus
// PB1..PBlen, with len clamped to the 27 payload bytes a packet can carry.
module infoframe_scheduler_checksum
    import infoframe_scheduler_pkg::*;
(
    input  packet_header_t header_i,
    input  packet_subs_t   sub_i,
    output logic [7:0]     checksum_o
);

    int         lenBytes;
    logic [7:0] sum;

    always_comb begin
        lenBytes = (int'(header_i[20:16]) > PB_MAX) ? PB_MAX : int'(header_i[20:16]);
        sum = header_i[7:0] + header_i[15:8] + header_i[23:16];
        for (int k = 1; k <= PB_MAX; k++) begin
            if (k <= lenBytes) begin
                sum = sum + pb_byte(sub_i, k);
            end
        end
        checksum_o = ~sum + 8'd1;
    end

endmodule

// File: rtl/infoframe_scheduler.sv
// Round-robin scheduler that sends every enabled InfoFrame source exactly once
// per video frame through the shared data-island packet slot.
module infoframe_scheduler
    import infoframe_scheduler_pkg::*;
#(
    parameter int NUM_SOURCES  = 4,
    parameter bit FIX_CHECKSUM = 1'b1
) (
    input logic            clk_pixel,
    input logic            reset,
    infoframe_scheduler_if.slave bus
);

    localparam int GW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    sched_state_t           state_q;
    logic [NUM_SOURCES-1:0] pending_q;
    logic [NUM_SOURCES-1:0] pending_d;
    logic [NUM_SOURCES-1:0] grantMask;
    logic [NUM_SOURCES-1:0] remaining;
    logic [GW-1:0]          rrPtr_q;
    logic [GW-1:0]          rrPtr_d;
    logic [GW-1:0]          grant;
    logic                   haveGrant;

    packet_header_t         header_q;
    packet_subs_t           sub_q;
    logic                   valid_q;
    logic [GW-1:0]          grant_q;
    logic                   overrun_q;
    logic [7:0]             missed_q;

    packet_header_t         selHeader;
    packet_subs_t           selSub;
    packet_subs_t           patchedSub;
    logic [7:0]             checksum;

    // First requesting source at or after ptr, wrapping around.
    function automatic logic [GW-1:0] rrSearch(input logic [NUM_SOURCES-1:0] req,
                                               input logic [GW-1:0] ptr);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            idx = (int'(ptr) + i) % NUM_SOURCES;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        return pick;
    endfunction

    always_comb begin
        grant     = rrSearch(pending_q, rrPtr_q);
        haveGrant = bus.packet_enable && (state_q == SEND);
        grantMask = haveGrant ? (NUM_SOURCES'(1) << grant) : '0;
        remaining = pending_q & ~grantMask;
        pending_d = bus.video_field_end ? (remaining | bus.src_enable) : remaining;
        rrPtr_d   = (grant == GW'(NUM_SOURCES - 1)) ? '0 : grant + GW'(1);
    end

    always_comb begin
        selHeader  = bus.src_header[grant];
        selSub     = bus.src_sub[grant];
        patchedSub = selSub;
        if (FIX_CHECKSUM) begin
            patchedSub[0][7:0] = checksum;
        end
    end

    infoframe_scheduler_checksum u_checksum (
        .header_i   (selHeader),
        .sub_i      (selSub),
        .checksum_o (checksum)
    );

    // SEND mirrors pending != 0; a grant and a frame-end arm in one cycle both apply.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rrPtr_q   <= '0;
            header_q  <= NULL_HEADER;
            sub_q     <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            overrun_q <= 1'b0;
            missed_q  <= 8'h00;
        end else begin
            pending_q <= pending_d;
            state_q   <= (pending_d != '0) ? SEND : IDLE;
            if (haveGrant) begin
                rrPtr_q <= rrPtr_d;
            end
            if (bus.packet_enable) begin
                if (haveGrant) begin
                    header_q <= selHeader;
                    sub_q    <= patchedSub;
                    valid_q  <= 1'b1;
                    grant_q  <= grant;
                end else begin
                    header_q <= NULL_HEADER;
                    sub_q    <= '0;
                    valid_q  <= 1'b0;
                end
            end
            if (bus.video_field_end && (remaining != '0)) begin
                overrun_q <= 1'b1;
                if (missed_q != 8'hFF) begin
                    missed_q <= missed_q + 8'd1;
                end
            end
        end
    end

    assign bus.header        = header_q;
    assign bus.sub           = sub_q;
    assign bus.packet_valid  = valid_q;
    assign bus.grant_id      = grant_q;
    assign bus.overrun       = overrun_q;
    assign bus.frames_missed = missed_q;

endmodule

// File: tb/tb_infoframe_scheduler.sv
// Scoreboard bench for infoframe_scheduler: a frame-level model predicts every
// packet/status update and a monitor compares when the DUT updates.
module tb_infoframe_scheduler;
    import infoframe_scheduler_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    infoframe_scheduler_if #(.NUM_SOURCES(N)) bus ();

    infoframe_scheduler #(
        .NUM_SOURCES  (N),
        .FIX_CHECKSUM (1'b1)
    ) dut (
        .clk_pixel (clk),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        packet_header_t header;
        packet_subs_t   sub;
        logic           valid;
        int             grant;
        logic           overrun;
        int             missed;
    } expItem_t;

    expItem_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    bit       pendM [N];
    int       rrM;
    expItem_t outM;

    function automatic logic [7:0] refChecksum(input packet_header_t h, input packet_subs_t s);
        logic [7:0] bytesArr [28];
        int         len;
        logic [7:0] sum;
        for (int k = 0; k < 28; k++) begin
            bytesArr[k] = 8'(s[k / 7] >> (8 * (k % 7)));
        end
        len = int'(h[20:16]);
        if (len > 27) len = 27;
        sum = h[7:0] + h[15:8] + h[23:16];
        for (int k = 1; k <= len; k++) sum = sum + bytesArr[k];
        return ~sum + 8'd1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) pendM[i] = 1'b0;
        rrM          = 0;
        outM.header  = '0;
        outM.sub     = '0;
        outM.valid   = 1'b0;
        outM.grant   = 0;
        outM.overrun = 1'b0;
        outM.missed  = 0;
    endtask

    task automatic randomizeSources();
        for (int i = 0; i < N; i++) begin
            bus.src_header[i] = 24'($urandom);
            for (int w = 0; w < 4; w++) begin
                bus.src_sub[i][w] = {24'($urandom), 32'($urandom)};
            end
        end
    endtask

    // Drive one cycle from a negedge, predict the result, return at the next negedge.
    task automatic applyStimulus(input bit pe, input bit vfe, input logic [N-1:0] en);
        int g;
        bit any;
        bus.packet_enable   = pe;
        bus.video_field_end = vfe;
        bus.src_enable      = en;
        if (pe) begin
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (g < 0 && pendM[(rrM + i) % N]) g = (rrM + i) % N;
            end
            if (g >= 0) begin
                pendM[g]          = 1'b0;
                rrM               = (g + 1) % N;
                outM.header       = bus.src_header[g];
                outM.sub          = bus.src_sub[g];
                outM.sub[0][7:0]  = refChecksum(bus.src_header[g], bus.src_sub[g]);
                outM.valid        = 1'b1;
                outM.grant        = g;
            end else begin
                outM.header = '0;
                outM.sub    = '0;
                outM.valid  = 1'b0;
            end
        end
        if (vfe) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (pendM[i]) any = 1'b1;
            if (any) begin
                outM.overrun = 1'b1;
                if (outM.missed < 255) outM.missed++;
            end
            for (int i = 0; i < N; i++) if (en[i]) pendM[i] = 1'b1;
        end
        if (pe || vfe) expQ.push_back(outM);
        @(posedge clk);
        @(negedge clk);
        bus.packet_enable   = 1'b0;
        bus.video_field_end = 1'b0;
    endtask

    task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic checkOutput();
        expItem_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard: DUT updated with no expected entry queued");
        end else begin
            e = expQ.pop_front();
            if (bus.header !== e.header || bus.sub !== e.sub || bus.packet_valid !== e.valid ||
                int'(bus.grant_id) != e.grant || bus.overrun !== e.overrun ||
                int'(bus.frames_missed) != e.missed) begin
                mismatched++;
                $display("[TB] FAIL packet @%0t: got v=%0d g=%0d hdr=%h ovr=%0d miss=%0d sub=%h; expected v=%0d g=%0d hdr=%h ovr=%0d miss=%0d sub=%h",
                         $time, bus.packet_valid, bus.grant_id, bus.header, bus.overrun,
                         bus.frames_missed, bus.sub, e.valid, e.grant, e.header, e.overrun,
                         e.missed, e.sub);
            end
        end
    endtask

    task automatic resetDut();
        bus.packet_enable   = 1'b0;
        bus.video_field_end = 1'b0;
        reset = 1'b1;
        modelReset();
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: the DUT updates its outputs after any packet_enable or field end.
    always @(posedge clk) begin
        if (!reset && (bus.packet_enable || bus.video_field_end)) begin
            #1;
            checkOutput();
        end
    end

    initial begin
        reset               = 1'b1;
        bus.packet_enable   = 1'b0;
        bus.video_field_end = 1'b0;
        bus.src_enable      = '0;
        randomizeSources();
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkValue("resetValid",  64'(bus.packet_valid),  64'd0);
        checkValue("resetHeader", 64'(bus.header),        64'd0);
        checkValue("resetGrant",  64'(bus.grant_id),      64'd0);
        checkValue("resetMissed", 64'(bus.frames_missed), 64'd0);

        // Full round-robin pass followed by null packets.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        repeat (6) begin
            randomizeSources();
            applyStimulus(1'b1, 1'b0, 4'b0000);
        end
        checkValue("nullAfterPass", 64'(bus.header), 64'd0);

        // Known AVI header: PB0 = -(82+02+0D+12) = 5D; PB14 is beyond len and untouched.
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'b0010);
        bus.src_header[1]          = 24'h0D0282;
        bus.src_sub[1]             = '0;
        bus.src_sub[1][0][15:8]    = 8'h12;
        bus.src_sub[1][2][7:0]     = 8'hAA;
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkValue("aviPb0",  64'(bus.sub[0][15:0]), 64'h125D);
        checkValue("aviPb14", 64'(bus.sub[2][7:0]),  64'hAA);

        // Grant and arm in the same cycle with only source 3 pending.
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'b1000);
        randomizeSources();
        applyStimulus(1'b1, 1'b1, 4'b0110);
        checkValue("sameCycleGrant",   64'(bus.grant_id), 64'd3);
        checkValue("sameCycleOverrun", 64'(bus.overrun),  64'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b0000);

        // Starved frame: carry-over then 2 before 0.
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'b0101);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b0101);
        checkValue("starveOverrun", 64'(bus.overrun),       64'd1);
        checkValue("starveMissed",  64'(bus.frames_missed), 64'd1);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkValue("carryFirst", 64'(bus.grant_id), 64'd2);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkValue("carrySecond", 64'(bus.grant_id), 64'd0);
        applyStimulus(1'b1, 1'b0, 4'b0000);

        // Saturation of the missed-frame counter.
        repeat (300) applyStimulus(1'b0, 1'b1, 4'b0001);
        checkValue("missedSaturate", 64'(bus.frames_missed), 64'hFF);

        // Reset landing between packet_enable and the output edge.
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'b1111);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        bus.packet_enable = 1'b1;
        #2;
        reset = 1'b1;
        modelReset();
        expQ.delete();
        #1;
        checkValue("midResetValid",  64'(bus.packet_valid), 64'd0);
        checkValue("midResetHeader", 64'(bus.header),       64'd0);
        checkValue("midResetSub0",   64'(bus.sub[0]),       64'd0);
        bus.packet_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b0011);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b0000);

        // Randomized traffic.
        resetDut();
        repeat (1500) begin
            randomizeSources();
            applyStimulus(($urandom % 3) == 0, ($urandom % 25) == 0, 4'($urandom));
        end

        @(negedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expected entries never seen, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
